// File: rtl/e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu_ctrl
// Function : E-stage multiply/divide controller. Owns architectural HI/LO,
//            computes mult/div results when an operation starts, and holds
//            them back for a programmable latency. While the unit is busy it
//            raises a stall request for MDU instructions waiting in D.
// Options  : MDU_MADD_EN - when defined, accepts madd/maddu/msub/msubu
//            (ops 9..12) as multi-cycle accumulate operations.
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,   // 1..31, must fit the 5-bit counter
    parameter int DIV_CYCLES  = 10   // 1..31, must fit the 5-bit counter
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_UseMDU,
    output logic        E_Busy,
    output logic        D_MDUStall,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_MDUOut
);

    // ------------------------------------------------------------------
    // Operation encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
    localparam logic [3:0] c_OP_MSUB  = 4'd11;
    localparam logic [3:0] c_OP_MSUBU = 4'd12;
`endif

    // Latency preload values, truncated to the counter width
    localparam logic [4:0] c_MULT_CNT = 5'(MULT_CYCLES);
    localparam logic [4:0] c_DIV_CNT  = 5'(DIV_CYCLES);

    // The unit is idle exactly when the latency counter is zero
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;

    logic [4:0]  w_cnt_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_pend_hi_nxt;
    logic [31:0] w_pend_lo_nxt;
    state_t      w_state;

    // ------------------------------------------------------------------
    // Arithmetic datapath (results are captured at start, released later)
    // ------------------------------------------------------------------
    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_a_zx;
    logic [63:0] w_b_zx;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;
    logic        w_div_zero;
`ifdef MDU_MADD_EN
    logic [63:0] w_hilo;
    logic [63:0] w_madd_s;
    logic [63:0] w_madd_u;
    logic [63:0] w_msub_s;
    logic [63:0] w_msub_u;
`endif

    // Operand extension and 64-bit products; low 64 bits of the
    // sign-extended product are the exact two's complement result
    always_comb begin
        w_a_sx   = {{32{E_A[31]}}, E_A};
        w_b_sx   = {{32{E_B[31]}}, E_B};
        w_a_zx   = {32'd0, E_A};
        w_b_zx   = {32'd0, E_B};
        w_prod_s = w_a_sx * w_b_sx;
        w_prod_u = w_a_zx * w_b_zx;
    end

    // Quotient/remainder; signed division truncates toward zero so the
    // remainder takes the dividend's sign. Zero divisor is handled below.
    always_comb begin
        w_div_zero = (E_B == 32'd0);
        w_quot_s   = $signed(E_A) / $signed(E_B);
        w_rem_s    = $signed(E_A) % $signed(E_B);
        w_quot_u   = E_A / E_B;
        w_rem_u    = E_A % E_B;
    end

`ifdef MDU_MADD_EN
    // Accumulate forms use HI/LO as they stand when the operation starts
    always_comb begin
        w_hilo   = {r_hi, r_lo};
        w_madd_s = w_hilo + w_prod_s;
        w_madd_u = w_hilo + w_prod_u;
        w_msub_s = w_hilo - w_prod_s;
        w_msub_u = w_hilo - w_prod_u;
    end
`endif

    // Current control state is a pure decode of the latency counter
    always_comb begin
        w_state = (r_cnt == 5'd0) ? S_IDLE : S_RUN;
    end

    // Next-state logic: start/move ops while idle, countdown and commit while running
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;

        case (w_state)
            S_IDLE: begin
                case (E_MDUOp)
                    c_OP_MULT: begin
                        if (E_Start) begin
                            {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
                            w_cnt_nxt = c_MULT_CNT;
                        end
                    end
                    c_OP_MULTU: begin
                        if (E_Start) begin
                            {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
                            w_cnt_nxt = c_MULT_CNT;
                        end
                    end
                    c_OP_DIV: begin
                        if (E_Start) begin
                            // A zero divisor still takes the full latency but leaves HI/LO intact
                            if (w_div_zero) begin
                                w_pend_hi_nxt = r_hi;
                                w_pend_lo_nxt = r_lo;
                            end else begin
                                w_pend_hi_nxt = w_rem_s;
                                w_pend_lo_nxt = w_quot_s;
                            end
                            w_cnt_nxt = c_DIV_CNT;
                        end
                    end
                    c_OP_DIVU: begin
                        if (E_Start) begin
                            if (w_div_zero) begin
                                w_pend_hi_nxt = r_hi;
                                w_pend_lo_nxt = r_lo;
                            end else begin
                                w_pend_hi_nxt = w_rem_u;
                                w_pend_lo_nxt = w_quot_u;
                            end
                            w_cnt_nxt = c_DIV_CNT;
                        end
                    end
`ifdef MDU_MADD_EN
                    c_OP_MADD: begin
                        if (E_Start) begin
                            {w_pend_hi_nxt, w_pend_lo_nxt} = w_madd_s;
                            w_cnt_nxt = c_MULT_CNT;
                        end
                    end
                    c_OP_MADDU: begin
                        if (E_Start) begin
                            {w_pend_hi_nxt, w_pend_lo_nxt} = w_madd_u;
                            w_cnt_nxt = c_MULT_CNT;
                        end
                    end
                    c_OP_MSUB: begin
                        if (E_Start) begin
                            {w_pend_hi_nxt, w_pend_lo_nxt} = w_msub_s;
                            w_cnt_nxt = c_MULT_CNT;
                        end
                    end
                    c_OP_MSUBU: begin
                        if (E_Start) begin
                            {w_pend_hi_nxt, w_pend_lo_nxt} = w_msub_u;
                            w_cnt_nxt = c_MULT_CNT;
                        end
                    end
`endif
                    c_OP_MTHI: w_hi_nxt = E_A;
                    c_OP_MTLO: w_lo_nxt = E_A;
                    default: ;
                endcase
            end
            S_RUN: begin
                // Last busy cycle: release the held result as the counter empties
                w_cnt_nxt = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_hi_nxt = r_pend_hi;
                    w_lo_nxt = r_pend_lo;
                end
            end
            default: ;
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 5'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
        end
    end

    // Status, stall request and mfhi/mflo read port
    always_comb begin
        E_Busy     = (w_state == S_RUN);
        D_MDUStall = D_UseMDU & (E_Start | E_Busy);
        E_HI       = r_hi;
        E_LO       = r_lo;
        case (E_MDUOp)
            c_OP_MFHI: E_MDUOut = r_hi;
            c_OP_MFLO: E_MDUOut = r_lo;
            default:   E_MDUOut = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu_ctrl
// Function : Self-checking bench for e_mdu_ctrl. A completion-time model
//            predicts HI/LO, busy and stall every cycle; directed vectors
//            pin the model with hand-computed literal results.
//            Define MDU_MADD_EN to exercise the accumulate ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic        E_Start;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_UseMDU;
    logic        E_Busy;
    logic        D_MDUStall;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
    logic [31:0] E_MDUOut;

    int n_vec = 0;
    int n_err = 0;

    e_mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDUOp   (E_MDUOp),
        .E_Start   (E_Start),
        .E_A       (E_A),
        .E_B       (E_B),
        .D_UseMDU  (D_UseMDU),
        .E_Busy    (E_Busy),
        .D_MDUStall(D_MDUStall),
        .E_HI      (E_HI),
        .E_LO      (E_LO),
        .E_MDUOut  (E_MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model: result is computed at start and lands at edge (start + N)
    // ------------------------------------------------------------------
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    logic        m_pend_v = 1'b0;
    int          m_edge = 0;
    int          m_done_edge = 0;
    logic        chk_en = 1'b0;

    function automatic logic is_start_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    function automatic int latency(input logic [3:0] op);
        return (op == 4'd3 || op == 4'd4) ? 10 : 5;
    endfunction

    function automatic logic [63:0] calc(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
        longint      sa;
        longint      sb;
        int          ia;
        int          ib;
        int          q;
        int          r;
        logic [63:0] acc;
        logic [63:0] pu;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ia  = a;
        ib  = b;
        acc = {hi, lo};
        pu  = {32'd0, a} * {32'd0, b};
        calc = acc;
        case (op)
            4'd1: calc = sa * sb;
            4'd2: calc = pu;
            4'd3: if (b != 0) begin q = ia / ib; r = ia % ib; calc = {r, q}; end
            4'd4: if (b != 0) calc = {a % b, a / b};
            4'd9:  calc = acc + 64'(sa * sb);
            4'd10: calc = acc + pu;
            4'd11: calc = acc - 64'(sa * sb);
            4'd12: calc = acc - pu;
            default: ;
        endcase
    endfunction

    // Model update on every rising edge
    always @(posedge clk) begin
        m_edge = m_edge + 1;
        if (reset) begin
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            m_pend_v = 1'b0;
            chk_en   = 1'b1;
        end else if (m_pend_v) begin
            if (m_edge == m_done_edge) begin
                m_hi     = m_pend[63:32];
                m_lo     = m_pend[31:0];
                m_pend_v = 1'b0;
            end
        end else if (E_Start && is_start_op(E_MDUOp)) begin
            m_pend      = calc(E_MDUOp, E_A, E_B, m_hi, m_lo);
            m_pend_v    = 1'b1;
            m_done_edge = m_edge + latency(E_MDUOp);
        end else if (E_MDUOp == 4'd7) begin
            m_hi = E_A;
        end else if (E_MDUOp == 4'd8) begin
            m_lo = E_A;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: all outputs against the model away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", {31'd0, E_Busy}, {31'd0, m_pend_v});
            cmp("stall", {31'd0, D_MDUStall}, {31'd0, D_UseMDU & (E_Start | m_pend_v)});
            cmp("hi", E_HI, m_hi);
            cmp("lo", E_LO, m_lo);
            cmp("mduout", E_MDUOut,
                (E_MDUOp == 4'd5) ? m_hi : ((E_MDUOp == 4'd6) ? m_lo : 32'd0));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input logic [3:0] op, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input logic use_mdu);
        E_MDUOp  = op;
        E_Start  = st;
        E_A      = a;
        E_B      = b;
        D_UseMDU = use_mdu;
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles after a start (bounded), D-stage MDU op waiting
    task automatic run_wait(input string name, input int exp_len);
        int n;
        n = 0;
        while (E_Busy === 1'b1 && n < 64) begin
            step(4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
            n++;
        end
        cmp(name, 32'(n), 32'(exp_len));
    endtask

    initial begin
        reset = 1'b1; E_MDUOp = 4'd0; E_Start = 1'b0; E_A = 32'd0; E_B = 32'd0; D_UseMDU = 1'b0;
        @(posedge clk); #1;
        // Reset state, with a start request pending in the same cycle
        E_Start = 1'b1; D_UseMDU = 1'b1;
        @(posedge clk); #1;
        cmp("rst_busy", {31'd0, E_Busy}, 32'd0);
        cmp("rst_stall", {31'd0, D_MDUStall}, 32'd1);
        cmp("rst_hi", E_HI, 32'd0);
        cmp("rst_lo", E_LO, 32'd0);
        reset = 1'b0;

        // Moves and reads
        step(4'd7, 1'b0, 32'h0000_1234, 32'd0, 1'b0);
        cmp("mthi", E_HI, 32'h0000_1234);
        step(4'd8, 1'b0, 32'h0000_5678, 32'd0, 1'b0);
        cmp("mtlo", E_LO, 32'h0000_5678);
        step(4'd5, 1'b0, 32'd0, 32'd0, 1'b1);
        cmp("mfhi", E_MDUOut, 32'h0000_1234);

        // mult -3 * 7
        step(4'd1, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b1);
        run_wait("mult_len", 5);
        cmp("mult_hi", E_HI, 32'hFFFF_FFFF);
        cmp("mult_lo", E_LO, 32'hFFFF_FFEB);

        // divu 100 / 7
        step(4'd4, 1'b1, 32'd100, 32'd7, 1'b1);
        run_wait("divu_len", 10);
        cmp("divu_lo", E_LO, 32'd14);
        cmp("divu_hi", E_HI, 32'd2);

        // div -7 / 2
        step(4'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_wait("div_len", 10);
        cmp("div_lo", E_LO, 32'hFFFF_FFFD);
        cmp("div_hi", E_HI, 32'hFFFF_FFFF);

        // Divide by zero keeps HI/LO
        step(4'd7, 1'b0, 32'h0000_1234, 32'd0, 1'b0);
        step(4'd3, 1'b1, 32'd5, 32'd0, 1'b1);
        run_wait("div0_len", 10);
        cmp("div0_hi", E_HI, 32'h0000_1234);
        cmp("div0_lo", E_LO, 32'hFFFF_FFFD);

        // multu largest operands
        step(4'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_wait("multu_len", 5);
        cmp("multu_hi", E_HI, 32'hFFFF_FFFE);
        cmp("multu_lo", E_LO, 32'h0000_0001);

        // Start with non-start ops is ignored
        step(4'd0, 1'b1, 32'd3, 32'd3, 1'b0);
        cmp("ign_op0", {31'd0, E_Busy}, 32'd0);
        step(4'd5, 1'b1, 32'd3, 32'd3, 1'b0);
        cmp("ign_op5", {31'd0, E_Busy}, 32'd0);
        step(4'd13, 1'b1, 32'd3, 32'd3, 1'b0);
        cmp("ign_op13", {31'd0, E_Busy}, 32'd0);
        step(4'd6, 1'b0, 32'd0, 32'd0, 1'b0);
        cmp("mflo", E_MDUOut, 32'h0000_0001);

        // Reset in busy cycle 3 of a mult aborts it
        step(4'd1, 1'b1, 32'd5, 32'd5, 1'b1);
        step(4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        step(4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        reset = 1'b1;
        step(4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        reset = 1'b0;
        cmp("abort_busy", {31'd0, E_Busy}, 32'd0);
        cmp("abort_hi", E_HI, 32'd0);
        cmp("abort_lo", E_LO, 32'd0);
        for (int i = 0; i < 6; i++) step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        cmp("late_hi", E_HI, 32'd0);
        cmp("late_lo", E_LO, 32'd0);

        // maddu on HI=0, LO=FFFFFFFF
        step(4'd8, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        step(4'd10, 1'b1, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        run_wait("maddu_len", 5);
        cmp("maddu_hi", E_HI, 32'd1);
        cmp("maddu_lo", E_LO, 32'd0);
        step(4'd11, 1'b1, 32'd2, 32'd3, 1'b0);
        run_wait("msub_len", 5);
        cmp("msub_hi", E_HI, 32'd0);
        cmp("msub_lo", E_LO, 32'hFFFF_FFFA);
`else
        cmp("maddu_busy", {31'd0, E_Busy}, 32'd0);
        step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        cmp("maddu_hi", E_HI, 32'd0);
        cmp("maddu_lo", E_LO, 32'hFFFF_FFFF);
`endif

        step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
